// File: rtl/win_apply.sv
// win_apply: streaming analysis-window applicator.
//
// Numbers incoming signed samples 0..2**FRAME_LOG2-1 within a frame, addresses the
// window coefficient ROM with that index, and multiplies each sample by the returned
// unsigned Q1.17 coefficient. Two-stage pipeline with a single global enable so that
// backpressure freezes everything in place.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_data signed sample, in_sof forces index 0
//   win_addr            ROM address (upper bits tied to 0)
//   win                 ROM data, registered by the ROM (valid one edge after address)
//   out_valid/out_ready output handshake; out_data windowed sample
//   out_sof/out_eof     out_data is the first / last sample of a frame
module win_apply #(
    parameter int unsigned DATA_W     = 18,
    parameter int unsigned COEF_W     = 18,
    parameter int unsigned FRAME_LOG2 = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_sof,
    output logic        [11:0]       win_addr,
    input  logic        [COEF_W-1:0] win,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sof,
    output logic                     out_eof
);

    localparam int unsigned PROD_W = DATA_W + COEF_W + 1;

    localparam logic [FRAME_LOG2-1:0] IDX_ZERO = '0;
    localparam logic [FRAME_LOG2-1:0] IDX_LAST = '1;
    localparam logic [FRAME_LOG2-1:0] IDX_ONE  = {{(FRAME_LOG2-1){1'b0}}, 1'b1};

    logic                     en;
    logic                     accept;
    logic [FRAME_LOG2-1:0]    idx;

    logic [FRAME_LOG2-1:0]    cnt_q, cnt_d;
    logic                     s1_valid_q, s1_valid_d;
    logic signed [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [FRAME_LOG2-1:0]    s1_idx_q, s1_idx_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_sof_q, out_sof_d;
    logic                     out_eof_q, out_eof_d;

    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] prod;
    logic                     unused_prod;

    always_comb begin
        en     = ~out_valid_q | out_ready;
        accept = in_valid & en;
        idx    = in_sof ? IDX_ZERO : cnt_q;

        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = idx + IDX_ONE;
        end

        // While stalled the ROM keeps re-reading the stage-1 index, so the registered
        // coefficient still belongs to s1 when the stall releases.
        win_addr = {{(12-FRAME_LOG2){1'b0}}, (en ? idx : s1_idx_q)};

        // Coefficient is unsigned: zero-extend, then multiply as signed.
        data_ext = PROD_W'(s1_data_q);
        coef_ext = PROD_W'({1'b0, win});
        prod     = data_ext * coef_ext;

        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_idx_d    = s1_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;

        if (en) begin
            s1_valid_d  = accept;
            s1_data_d   = in_data;
            s1_idx_d    = idx;
            out_valid_d = s1_valid_q;
            // Arithmetic shift by 17 (floor); coefficient <= 1.0 so no saturation.
            out_data_d  = prod[DATA_W+COEF_W-2:COEF_W-1];
            out_sof_d   = s1_valid_q & (s1_idx_q == IDX_ZERO);
            out_eof_d   = s1_valid_q & (s1_idx_q == IDX_LAST);
        end
    end

    assign unused_prod = ^{prod[PROD_W-1:DATA_W+COEF_W-1], prod[COEF_W-2:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_idx_q    <= s1_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_win_apply.sv
// Self-checking bench for win_apply: Hann ROM model, scoreboard of expected outputs,
// a vector table for hand-derived cases, and directed stall/bubble/resync/reset runs.
module tb_win_apply;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [17:0] in_data;
    logic               in_sof;
    logic [11:0]        win_addr;
    logic [17:0]        win;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] out_data;
    logic               out_sof;
    logic               out_eof;

    win_apply #(
        .DATA_W     (18),
        .COEF_W     (18),
        .FRAME_LOG2 (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .win_addr  (win_addr),
        .win       (win),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic signed [17:0] data;
        logic               sof;
        logic               eof;
        int                 idx;
    } exp_t;

    typedef struct {
        int                 fill;
        logic signed [17:0] data;
        logic               sof;
        logic signed [17:0] exp_data;
        logic               exp_sof;
        logic               exp_eof;
    } vec_t;

    exp_t        sb[$];
    int unsigned rom[256];
    int          vectors     = 0;
    int          miscompares = 0;
    int          m_cnt       = 0;

    // Registered ROM: data follows the address by one edge.
    always @(posedge clock) win <= 18'(rom[win_addr[7:0]]);

    function automatic logic signed [17:0] model(input logic signed [17:0] d, input int idx);
        longint p;
        p = longint'(d) * longint'(rom[idx]);
        return 18'(p >>> 17);
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Output monitor: every transfer must match the head of the scoreboard.
    exp_t mon_e;
    always @(negedge clock) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected output: got data %0d, expected no output", out_data);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("out_data idx%0d", mon_e.idx), out_data, mon_e.data);
                check($sformatf("out_sof idx%0d", mon_e.idx), out_sof, mon_e.sof);
                check($sformatf("out_eof idx%0d", mon_e.idx), out_eof, mon_e.eof);
            end
        end
    end

    // Drive one sample, wait for acceptance, check the ROM address, push expectation.
    // Returns 1 time unit after the accepting edge with in_valid low.
    task automatic send(input logic signed [17:0] d, input logic s,
                        input logic signed [17:0] ed, input logic es, input logic ee);
        int   idx;
        int   waited;
        exp_t e;
        idx      = s ? 0 : m_cnt;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        waited   = 0;
        @(negedge clock);
        while (!in_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept timeout idx%0d: in_ready %0d, expected 1", idx, in_ready);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            return;
        end
        check($sformatf("win_addr idx%0d", idx), win_addr, idx);
        e.data = ed;
        e.sof  = es;
        e.eof  = ee;
        e.idx  = idx;
        sb.push_back(e);
        m_cnt = (idx + 1) % 256;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_m(input logic signed [17:0] d, input logic s);
        int idx;
        idx = s ? 0 : m_cnt;
        send(d, s, model(d, idx), idx == 0, idx == 255);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        check("in_ready during reset", in_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        m_cnt = 0;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_sof", out_sof, 0);
        check("reset out_eof", out_eof, 0);
        check("reset in_ready", in_ready, 1);
    endtask

    task automatic drain(input string name);
        repeat (4) @(posedge clock);
        #1;
        check({name, " scoreboard drained"}, sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t               tbl[9];
        logic signed [17:0] cap_data;
        logic               cap_sof;

        tbl[0] = '{0,   18'sd7,      1'b1, 18'sd0,    1'b1, 1'b0};  // idx0
        tbl[1] = '{0,   -18'sd1000,  1'b0, -18'sd1,   1'b0, 1'b0};  // idx1, coef 20
        tbl[2] = '{0,   18'sd1000,   1'b1, 18'sd0,    1'b1, 1'b0};  // resync to idx0
        tbl[3] = '{0,   18'sd1000,   1'b0, 18'sd0,    1'b0, 1'b0};  // idx1
        tbl[4] = '{62,  18'sd131071, 1'b0, 18'sd65535, 1'b0, 1'b0}; // idx64
        tbl[5] = '{63,  18'sh20000,  1'b0, 18'sh20000, 1'b0, 1'b0}; // idx128, coef 1.0
        tbl[6] = '{126, -18'sd1,     1'b0, -18'sd1,   1'b0, 1'b1};  // idx255
        tbl[7] = '{0,   18'sd131071, 1'b0, 18'sd0,    1'b1, 1'b0};  // wrap to idx0
        tbl[8] = '{0,   18'sd131071, 1'b0, 18'sd19,   1'b0, 1'b0};  // idx1

        for (int n = 0; n < 256; n++) begin
            real v;
            v = 0.5 * (1.0 - $cos(2.0 * 3.14159265358979 * n / 256.0)) * 131072.0;
            rom[n] = $rtoi(v + 0.5);
        end

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sof    = 1'b0;
        out_ready = 1'b1;

        // Vector table.
        do_reset();
        for (int r = 0; r < 9; r++) begin
            for (int f = 0; f < tbl[r].fill; f++) begin
                send_m(18'(((f * 977) % 4001) - 2000), 1'b0);
            end
            send(tbl[r].data, tbl[r].sof, tbl[r].exp_data, tbl[r].exp_sof, tbl[r].exp_eof);
        end
        drain("table");

        // Full frame of +131071 with a 5-cycle stall while idx100/101 are in flight.
        do_reset();
        send_m(18'sd131071, 1'b0);
        check("latency out_valid after accept edge", out_valid, 0);
        @(posedge clock);
        #1;
        check("latency out_valid one edge later", out_valid, 1);
        check("latency out_sof", out_sof, 1);
        for (int i = 1; i < 256; i++) begin
            if (i == 102) begin
                out_ready = 1'b0;
                cap_data  = out_data;
                cap_sof   = out_sof;
                in_valid  = 1'b1;
                in_data   = 18'sd5;
                repeat (5) begin
                    @(posedge clock);
                    #1;
                    check("stall in_ready", in_ready, 0);
                    check("stall out_valid", out_valid, 1);
                    check("stall out_data", out_data, cap_data);
                    check("stall out_sof", out_sof, cap_sof);
                    check("stall win_addr", win_addr, 101);
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            send_m(18'sd131071, 1'b0);
        end
        drain("frame");

        // Bubbles: one idle cycle after every accepted sample.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send_m(18'((i * 3001) - 60000), 1'b0);
            if (i > 0) check("bubble gap out_valid", out_valid, 0);
            @(posedge clock);
            #1;
            check("bubble out_valid", out_valid, 1);
        end
        drain("bubble");

        // Resync mid-frame at cnt=37.
        do_reset();
        for (int i = 0; i < 37; i++) send_m(18'(131071 - i), 1'b0);
        send_m(18'sd131071, 1'b1);
        send_m(18'sd131071, 1'b0);
        send_m(-18'sd1000, 1'b0);
        drain("resync");

        // Reset with two samples in flight.
        send_m(18'sd1111, 1'b0);
        send_m(18'sd2222, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid reset out_valid", out_valid, 0);
        check("mid reset in_ready", in_ready, 1);
        reset = 1'b0;
        sb.delete();
        m_cnt = 0;
        send_m(18'sd4321, 1'b0);
        send_m(18'sd4321, 1'b0);
        drain("post reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
